mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request pulse; sampled on rising edge of clock.
REQ-005 Port: op  input  2  operation code: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 Port: operandA  input  32  first operand, fed from register-bank data1; dividend for DIV/DIVU.
REQ-007 Port: operandB  input  32  second operand, fed from register-bank data2; divisor for DIV/DIVU.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; results valid and updated.
REQ-010 Port: hi  output  32  upper product half, or remainder.
REQ-011 Port: lo  output  32  lower product half, or quotient.
REQ-012 Port: divByZero  output  1  high with done when a DIV or DIVU had operandB == 0; held until the next done.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-014 In IDLE or FINISH, start=1 at edge T SHALL capture op, operandA and operandB and enter RUN.
REQ-015 start SHALL be ignored while in RUN, and the operands SHALL NOT be re-sampled.
REQ-016 RUN SHALL last exactly 32 cycles: one iteration per cycle (shift-add multiply, restoring divide) using an internal 6-bit counter.
REQ-017 busy SHALL be 1 during cycles T+1..T+32 and 0 otherwise.
REQ-018 FINISH SHALL occur at cycle T+33: done=1, and hi, lo and divByZero update on the edge entering FINISH.
REQ-019 FINISH SHALL return to IDLE after one cycle unless start=1 in that cycle.
REQ-020 Latency from start to done SHALL be a fixed 33 cycles for all ops, including divide-by-zero.
REQ-021 hi, lo and divByZero SHALL hold their values between done pulses.
REQ-022 Signed ops SHALL operate on magnitudes and apply sign correction in FINISH.
REQ-023 MULT/MULTU SHALL produce {hi,lo} = the exact 64-bit product.
REQ-024 DIV/DIVU SHALL produce lo = quotient and hi = remainder.
REQ-025 Signed quotients SHALL truncate toward zero, and the remainder sign SHALL equal the dividend sign.
REQ-026 Divide by zero SHALL force divByZero=1, hi=operandA and lo=32'hFFFFFFFF.
REQ-027 DIV with 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000, hi=0 and divByZero=0.
REQ-028 A MULT/MULTU result SHALL drive divByZero=0.

Reset
REQ-029 reset=0 SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, divByZero=0 and clear all internal registers, regardless of state.
REQ-030 While reset=0, start SHALL be ignored.
REQ-031 After reset deasserts, the first rising edge with start=1 SHALL begin a new operation.
REQ-032 An operation interrupted by reset SHALL produce no done pulse.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done exactly 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 32 cycles.
REQ-034 MULT -5 x -6 -> hi=0, lo=30; MULT -5 x 6 -> hi=0xFFFFFFFF, lo=0xFFFFFFE2.
REQ-035 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2.
REQ-036 DIVU 0x1234 / 0 -> divByZero=1, hi=0x1234, lo=0xFFFFFFFF at cycle T+33; a following MULT clears divByZero at its done.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 Start MULTU 3x4, then pulse start with different operands at RUN cycle 5, then reset at RUN cycle 10 of a second op -> first result hi=0, lo=12 unaffected by the second start; on reset all outputs 0 immediately, no done pulse, back-to-back start in FINISH accepted.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit: shift-add multiply, restoring divide,
// one iteration per cycle, fixed 33-cycle latency from start to done.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divByZero
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} stateType;

    stateType         state, nextState;
    logic [5:0]       count;
    logic             isDiv, negProd, negRem, zeroDiv;
    logic [WIDTH-1:0] savedA, acc, low, mcand;

    logic             signedOp, accept, lastStep;
    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH+1:0] divDiff;
    logic             divFits;
    logic [WIDTH-1:0] stepAcc, stepLow;
    logic [2*WIDTH-1:0] product, signedProduct;

    assign signedOp = ~op[0];
    assign absA     = (signedOp && operandA[WIDTH-1]) ? -operandA : operandA;
    assign absB     = (signedOp && operandB[WIDTH-1]) ? -operandB : operandB;
    assign accept   = start && (state != RUN);
    assign lastStep = (state == RUN) && (count == 6'd31);

    // One iteration of either algorithm; acc holds the running high half / partial remainder.
    always_comb begin
        mulSum   = low[0] ? ({1'b0, acc} + {1'b0, mcand}) : {1'b0, acc};
        divShift = {acc, low[WIDTH-1]};
        divDiff  = {1'b0, divShift} - {2'b00, mcand};
        divFits  = ~divDiff[WIDTH+1];
        if (isDiv) begin
            stepAcc = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
            stepLow = {low[WIDTH-2:0], divFits};
        end else begin
            stepAcc = mulSum[WIDTH:1];
            stepLow = {mulSum[0], low[WIDTH-1:1]};
        end
        product       = {stepAcc, stepLow};
        signedProduct = negProd ? -product : product;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (start) nextState = RUN;
            RUN:     if (count == 6'd31) nextState = FINISH;
            FINISH:  nextState = start ? RUN : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == FINISH);
    end

    // NOTE: every datapath and result register is cleared by the async reset so an
    // interrupted operation leaves nothing behind.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            isDiv     <= 1'b0;
            negProd   <= 1'b0;
            negRem    <= 1'b0;
            zeroDiv   <= 1'b0;
            savedA    <= '0;
            acc       <= '0;
            low       <= '0;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            divByZero <= 1'b0;
        end else if (accept) begin
            count   <= '0;
            isDiv   <= op[1];
            negProd <= signedOp && (operandA[WIDTH-1] ^ operandB[WIDTH-1]);
            negRem  <= signedOp && operandA[WIDTH-1];
            zeroDiv <= op[1] && (operandB == '0);
            savedA  <= operandA;
            acc     <= '0;
            low     <= op[1] ? absA : absB;
            mcand   <= op[1] ? absB : absA;
        end else if (state == RUN) begin
            count <= count + 6'd1;
            acc   <= stepAcc;
            low   <= stepLow;
            if (lastStep) begin
                if (!isDiv) begin
                    {hi, lo}  <= signedProduct;
                    divByZero <= 1'b0;
                end else if (zeroDiv) begin
                    hi        <= savedA;
                    lo        <= '1;
                    divByZero <= 1'b1;
                end else begin
                    hi        <= negRem  ? -stepAcc : stepAcc;
                    lo        <= negProd ? -stepLow : stepLow;
                    divByZero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, results, divide-by-zero,
// start-while-busy, back-to-back start and mid-operation reset.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic        busy, done, divByZero;
    logic [31:0] hi, lo;

    int checkCount = 0;
    int passCount  = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operandA(operandA), .operandB(operandB),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .divByZero(divByZero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or the budget runs out).
    // A nonzero pulseAt re-asserts start with other operands in that RUN cycle.
    task automatic runOp(input string tag, input logic [1:0] opCode, input logic [31:0] a,
                         input logic [31:0] b, input int pulseAt);
        int cycles = 0;
        int busyCycles = 0;
        op = opCode; operandA = a; operandB = b; start = 1'b1;
        do begin
            @(negedge clock);
            cycles++;
            if (busy) busyCycles++;
            if (pulseAt != 0 && cycles == pulseAt) begin
                start = 1'b1; op = MULT; operandA = 32'd5; operandB = 32'd6;
            end else begin
                start = 1'b0;
            end
        end while (!done && cycles < 100);
        check({tag, " latency"}, 64'(cycles), 64'd33);
        check({tag, " busy cycles"}, 64'(busyCycles), 64'd32);
    endtask

    initial begin
        int doneSeen;
        logic [31:0] heldHi, heldLo;

        #13;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset divByZero", 64'(divByZero), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        runOp("MULTU max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("MULTU max hi", 64'(hi), 64'hFFFF_FFFE);
        check("MULTU max lo", 64'(lo), 64'h0000_0001);
        check("MULTU max dbz", 64'(divByZero), 64'd0);
        @(negedge clock);

        runOp("MULT -5*-6", MULT, -32'sd5, -32'sd6, 0);
        check("MULT -5*-6", {hi, lo}, 64'd30);
        @(negedge clock);
        runOp("MULT -5*6", MULT, -32'sd5, 32'sd6, 0);
        check("MULT -5*6", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFE2);

        runOp("DIV -7/2", DIV, -32'sd7, 32'sd2, 0);
        check("DIV -7/2 lo", 64'(lo), 64'hFFFF_FFFD);
        check("DIV -7/2 hi", 64'(hi), 64'hFFFF_FFFF);
        @(negedge clock);
        runOp("DIV 7/-2", DIV, 32'sd7, -32'sd2, 0);
        check("DIV 7/-2 lo", 64'(lo), 64'hFFFF_FFFD);
        check("DIV 7/-2 hi", 64'(hi), 64'd1);
        @(negedge clock);
        runOp("DIVU 100/7", DIVU, 32'd100, 32'd7, 0);
        check("DIVU 100/7 lo", 64'(lo), 64'd14);
        check("DIVU 100/7 hi", 64'(hi), 64'd2);
        @(negedge clock);

        runOp("DIVU by zero", DIVU, 32'h1234, 32'd0, 0);
        check("DIVU by zero dbz", 64'(divByZero), 64'd1);
        check("DIVU by zero hi", 64'(hi), 64'h1234);
        check("DIVU by zero lo", 64'(lo), 64'hFFFF_FFFF);
        repeat (3) @(negedge clock);
        check("hold dbz", 64'(divByZero), 64'd1);
        check("hold hi", 64'(hi), 64'h1234);
        check("hold done low", 64'(done), 64'd0);
        runOp("MULT after dbz", MULT, 32'd2, 32'd3, 0);
        check("MULT clears dbz", 64'(divByZero), 64'd0);
        check("MULT 2*3", {hi, lo}, 64'd6);
        @(negedge clock);

        runOp("DIV min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("DIV min/-1 lo", 64'(lo), 64'h8000_0000);
        check("DIV min/-1 hi", 64'(hi), 64'd0);
        check("DIV min/-1 dbz", 64'(divByZero), 64'd0);
        @(negedge clock);

        runOp("MULTU 3*4 with start pulse", MULTU, 32'd3, 32'd4, 5);
        check("MULTU 3*4 lo", 64'(lo), 64'd12);
        check("MULTU 3*4 hi", 64'(hi), 64'd0);

        // Back-to-back start while in FINISH, then reset at RUN cycle 10.
        op = MULTU; operandA = 32'd7; operandB = 32'd9; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("back-to-back accepted", 64'(busy), 64'd1);
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset done", 64'(done), 64'd0);
        check("mid reset outputs", {hi, lo}, 64'd0);
        check("mid reset dbz", 64'(divByZero), 64'd0);
        start = 1'b1;
        repeat (3) @(negedge clock);
        check("start ignored in reset", 64'(busy), 64'd0);
        start = 1'b0;
        reset = 1'b1;
        doneSeen = 0;
        heldHi = hi; heldLo = lo;
        repeat (40) begin
            @(negedge clock);
            if (done) doneSeen++;
        end
        check("no done after reset", 64'(doneSeen), 64'd0);
        check("outputs stay cleared", {heldHi, heldLo, hi, lo} == 128'd0 ? 64'd1 : 64'd0, 64'd1);

        runOp("DIVU after reset", DIVU, 32'd100, 32'd7, 0);
        check("DIVU after reset", {hi, lo}, {32'd2, 32'd14});

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
